// File: rtl/ltc_spi_master.sv
// Mode-0 SPI master for the LTC connector: start/busy/done command side,
// SCLK/MOSI/CS_n generation and synchronized MISO capture, all outputs registered.
module ltc_spi_master #(
    parameter int DATA_W   = 8,
    parameter int HALF_DIV = 25,
    parameter int GAP_DIV  = 25
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic              spi_cs_n,
    input  logic              spi_miso
);

    localparam int CNT_MAX = (HALF_DIV > GAP_DIV) ? HALF_DIV : GAP_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_W) + 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        HOLD,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d, bit_inc;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              miso_meta, miso_sync;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            miso_meta <= spi_miso;
            miso_sync <= miso_meta;
        end
    end

    // Every output is computed one cycle ahead here so it leaves a flop;
    // MISO is sampled together with each SCLK rise.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        bit_inc   = bit_q + 1'b1;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = SETUP;
                    tx_sr_d = tx_data;
                    rx_sr_d = '0;
                    bit_d   = '0;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = tx_data[DATA_W-1];
                end
            end
            SETUP: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = SHIFT_HI;
                    sclk_d  = 1'b1;
                    rx_sr_d = (rx_sr_q << 1) | DATA_W'(miso_sync);
                end
            end
            SHIFT_HI: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = SHIFT_LO;
                    sclk_d  = 1'b0;
                    bit_d   = bit_inc;
                    if (bit_inc != BIT_LAST) begin
                        tx_sr_d = tx_sr_q << 1;
                        mosi_d  = tx_sr_d[DATA_W-1];
                    end
                end
            end
            SHIFT_LO: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        state_d = SHIFT_HI;
                        sclk_d  = 1'b1;
                        rx_sr_d = (rx_sr_q << 1) | DATA_W'(miso_sync);
                    end
                end
            end
            HOLD: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    state_d   = GAP;
                    cs_n_d    = 1'b1;
                    done_d    = 1'b1;
                    rx_data_d = rx_sr_q;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rx_data  = rx_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_ltc_spi_master.sv
// Scoreboard bench for ltc_spi_master: stimulus pushes expected words, a
// negedge monitor checks framing, SCLK timing, MOSI bits and rx_data on done.
module tb_ltc_spi_master;

    localparam int DATA_W   = 8;
    localparam int HALF_DIV = 4;
    localparam int GAP_DIV  = 3;

    typedef struct packed {
        logic [7:0] rx;
        logic [7:0] tx;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       busy;
    logic       done;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_cs_n;
    logic       spi_miso;

    int         misoMode;
    logic [7:0] patWord;
    logic       patPrevSclk;

    exp_t       expQ[$];
    exp_t       expCur;
    int         checks = 0;
    int         errors = 0;
    int         doneCnt = 0;
    int         riseCnt = 0;
    int         lowCnt = 0;
    int         gapCnt = 0;
    int         perCnt = 0;
    logic [7:0] mosiWord = '0;
    logic       prevCs = 1'b1;
    logic       prevSclk = 1'b0;
    logic       gapArm = 1'b0;
    int         doneBase;

    ltc_spi_master #(
        .DATA_W  (DATA_W),
        .HALF_DIV(HALF_DIV),
        .GAP_DIV (GAP_DIV)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .busy    (busy),
        .done    (done),
        .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n),
        .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    // Slave model for the pattern test: reloads while deselected, advances one bit per SCLK fall.
    assign spi_miso = (misoMode == 0) ? 1'b1 : (misoMode == 1) ? spi_mosi : patWord[7];

    initial begin
        patWord     = 8'h96;
        patPrevSclk = 1'b0;
        forever begin
            @(negedge clk);
            if (spi_cs_n)
                patWord = 8'h96;
            else if (patPrevSclk && !spi_sclk)
                patWord = {patWord[6:0], 1'b0};
            patPrevSclk = spi_sclk;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        checkOutput("idle_timeout", 32'(busy), 0);
    endtask

    task automatic waitBusy();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) return;
        end
        checkOutput("busy_timeout", 32'(busy), 1);
    endtask

    task automatic waitRise(input int n);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (riseCnt >= n) return;
        end
        checkOutput("rise_timeout", riseCnt, n);
    endtask

    task automatic applyStimulus(input logic [7:0] tx, input logic [7:0] rxExp);
        waitIdle();
        start   = 1'b1;
        tx_data = tx;
        expQ.push_back('{rx: rxExp, tx: tx});
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: every sample is taken on the falling clk edge, half a cycle after outputs move.
    initial begin
        forever begin
            @(negedge clk);
            perCnt++;
            if (!spi_cs_n && prevCs) begin
                if (gapArm)
                    checkOutput("gap_len", gapCnt, GAP_DIV + 1);
                lowCnt   = 0;
                riseCnt  = 0;
                mosiWord = '0;
            end
            if (!spi_cs_n)
                lowCnt++;
            else
                gapCnt = prevCs ? gapCnt + 1 : 1;
            if (spi_sclk && !prevSclk) begin
                checkOutput("sclk_cs_low", 32'(spi_cs_n), 0);
                if (riseCnt > 0)
                    checkOutput("sclk_period", perCnt, 2 * HALF_DIV);
                perCnt   = 0;
                riseCnt++;
                mosiWord = {mosiWord[6:0], spi_mosi};
            end
            if (done) begin
                doneCnt++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", 32'(doneCnt), 0);
                end else begin
                    expCur = expQ.pop_front();
                    checkOutput("rx_data", 32'(rx_data), 32'(expCur.rx));
                    checkOutput("mosi_bits", 32'(mosiWord), 32'(expCur.tx));
                    checkOutput("cs_low_len", lowCnt, (2 * DATA_W + 2) * HALF_DIV);
                    checkOutput("rise_count", riseCnt, DATA_W);
                    checkOutput("done_cs_edge", {30'd0, prevCs, spi_cs_n}, 32'b01);
                end
            end
            prevCs   = spi_cs_n;
            prevSclk = spi_sclk;
        end
    end

    initial begin
        reset_n  = 1'b0;
        start    = 1'b1;
        tx_data  = 8'hFF;
        misoMode = 0;

        repeat (3) @(negedge clk);
        checkOutput("rst_cs_n", 32'(spi_cs_n), 1);
        checkOutput("rst_sclk", 32'(spi_sclk), 0);
        checkOutput("rst_mosi", 32'(spi_mosi), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_rx", 32'(rx_data), 0);
        start   = 1'b0;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("post_rst_cs_n", 32'(spi_cs_n), 1);
        checkOutput("post_rst_busy", 32'(busy), 0);

        // Single transfer with MISO held high.
        applyStimulus(8'hA5, 8'hFF);

        // Back-to-back loopback with start held high across both transfers.
        waitIdle();
        misoMode = 1;
        start    = 1'b1;
        tx_data  = 8'h3C;
        expQ.push_back('{rx: 8'h3C, tx: 8'h3C});
        expQ.push_back('{rx: 8'hC3, tx: 8'hC3});
        waitBusy();
        tx_data = 8'hC3;
        @(negedge clk);
        gapArm = 1'b1;
        waitIdle();
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_busy", 32'(busy), 1);
        @(negedge clk);
        gapArm = 1'b0;

        // A start pulse in the middle of SHIFT must be ignored.
        waitIdle();
        doneBase = doneCnt;
        applyStimulus(8'h5A, 8'h5A);
        repeat (30) @(negedge clk);
        tx_data = 8'h11;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitIdle();
        repeat (10) @(negedge clk);
        checkOutput("ignored_start_dones", doneCnt - doneBase, 1);
        checkOutput("ignored_start_cs_n", 32'(spi_cs_n), 1);

        // Reset after the third SCLK rise aborts with no done.
        misoMode = 0;
        doneBase = doneCnt;
        start    = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        waitRise(3);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_cs_n", 32'(spi_cs_n), 1);
        checkOutput("abort_sclk", 32'(spi_sclk), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_done", 32'(done), 0);
        checkOutput("abort_rx", 32'(rx_data), 0);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);
        checkOutput("abort_no_done", doneCnt - doneBase, 0);

        // MISO driven by the slave model.
        misoMode = 2;
        applyStimulus(8'h69, 8'h96);
        waitIdle();
        repeat (5) @(negedge clk);

        checkOutput("queue_empty", expQ.size(), 0);
        checkOutput("total_dones", doneCnt, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
